// File: rtl/host_mem_responder_if.sv
// Host/MMIO bus between an initiator (master) and the host-side memory responder (slave).
// It also carries the UART byte stream and the cycle-count result outputs.
interface host_mem_responder_if;
  logic [63:0]  cpu_addr;
  logic         host_rgo;
  logic         host_re;
  logic         host_wgo;
  logic         host_we;
  logic [511:0] host_data_bus_write_out;
  logic         host_init;
  logic         host_rd_ready;
  logic         host_wr_ready;
  logic [511:0] host_data_bus_read_in;
  logic         mmio_wr_en;
  logic [63:0]  mmio_wr_addr;
  logic [31:0]  mmio_wr_data;
  logic         uart_valid;
  logic [7:0]   uart_byte;
  logic         uart_pop;
  logic         cyc_done;
  logic [31:0]  cyc_count;

  modport master (
    output cpu_addr, host_rgo, host_re, host_wgo, host_we, host_data_bus_write_out,
    output mmio_wr_en, mmio_wr_addr, mmio_wr_data, uart_pop,
    input  host_init, host_rd_ready, host_wr_ready, host_data_bus_read_in,
    input  uart_valid, uart_byte, cyc_done, cyc_count
  );

  modport slave (
    input  cpu_addr, host_rgo, host_re, host_wgo, host_we, host_data_bus_write_out,
    input  mmio_wr_en, mmio_wr_addr, mmio_wr_data, uart_pop,
    output host_init, host_rd_ready, host_wr_ready, host_data_bus_read_in,
    output uart_valid, uart_byte, cyc_done, cyc_count
  );
endinterface

// File: rtl/host_mem_responder.sv
// Host-side responder: serves 512-bit line reads/writes from a local store after a fixed latency.
// It also decodes edge/change-qualified MMIO writes into a UART byte FIFO and a cycle-count register.
module host_mem_responder #(
  parameter int LINE_AW     = 8,
  parameter int RD_LATENCY  = 4,
  parameter int INIT_CYCLES = 16,
  parameter int UART_DEPTH  = 8
) (
  input logic                 clk,
  input logic                 rst,
  host_mem_responder_if.slave bus_io
);
  localparam int ICW = $clog2(INIT_CYCLES + 1);
  localparam int LCW = $clog2(RD_LATENCY) + 1;
  localparam int UAW = $clog2(UART_DEPTH);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);
  localparam logic [LCW-1:0] LAT_LOAD  = LCW'(RD_LATENCY - 1);
  localparam logic [UAW:0]   UART_FULL = (UAW + 1)'(UART_DEPTH);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RWAIT, ST_RDATA} state_e;

  state_e             state_q, state_d;
  logic [ICW-1:0]     init_cnt_q, init_cnt_d;
  logic [LCW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [LINE_AW-1:0] idx_q, idx_d;
  logic               host_init_q, host_init_d;
  logic               rd_ready_q, rd_ready_d;
  logic               wr_ready_q, wr_ready_d;
  logic               line_we, line_re;
  logic [LINE_AW-1:0] req_idx;
  logic [511:0]       line_mem [0:(2**LINE_AW)-1];
  logic [511:0]       rd_line_q;
  logic               unused_addr_bits;

  assign req_idx          = bus_io.cpu_addr[2 +: LINE_AW];
  assign unused_addr_bits = ^{bus_io.cpu_addr[63:2+LINE_AW], bus_io.cpu_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    idx_d       = idx_q;
    host_init_d = 1'b0;
    rd_ready_d  = rd_ready_q;
    wr_ready_d  = 1'b0;
    line_we     = 1'b0;
    line_re     = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          host_init_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus_io.host_rgo) begin
          idx_d     = req_idx;
          lat_cnt_d = LAT_LOAD;
          state_d   = ST_RWAIT;
        // The wr_ready gap stops a still-held wgo from writing the line twice.
        end else if (bus_io.host_wgo && bus_io.host_we && !wr_ready_q) begin
          line_we    = 1'b1;
          wr_ready_d = 1'b1;
        end
      end
      ST_RWAIT: begin
        if (!bus_io.host_rgo) begin
          state_d = ST_IDLE;
        end else if (lat_cnt_q == '0) begin
          line_re    = 1'b1;
          rd_ready_d = 1'b1;
          state_d    = ST_RDATA;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      ST_RDATA: begin
        if (bus_io.host_re) begin
          rd_ready_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      idx_q       <= '0;
      host_init_q <= 1'b0;
      rd_ready_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      idx_q       <= idx_d;
      host_init_q <= host_init_d;
      rd_ready_q  <= rd_ready_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  // Line store is never reset; its read port is registered so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (line_we) line_mem[req_idx] <= bus_io.host_data_bus_write_out;
    if (line_re) rd_line_q <= line_mem[idx_q];
  end

  assign bus_io.host_init             = host_init_q;
  assign bus_io.host_rd_ready         = rd_ready_q;
  assign bus_io.host_wr_ready         = wr_ready_q;
  assign bus_io.host_data_bus_read_in = rd_ready_q ? rd_line_q : '0;

  logic        mmio_en_prev_q;
  logic [63:0] mmio_addr_last_q;
  logic [31:0] mmio_data_last_q;
  logic        mmio_accept, uart_push, cyc_wr;
  logic        cyc_done_q;
  logic [31:0] cyc_count_q;

  assign mmio_accept = bus_io.mmio_wr_en &&
                       (!mmio_en_prev_q || (bus_io.mmio_wr_addr != mmio_addr_last_q) ||
                        (bus_io.mmio_wr_data != mmio_data_last_q));
  assign uart_push   = mmio_accept && bus_io.mmio_wr_addr[18];
  assign cyc_wr      = mmio_accept && (bus_io.mmio_wr_addr == 64'h10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmio_en_prev_q   <= 1'b0;
      mmio_addr_last_q <= '0;
      mmio_data_last_q <= '0;
      cyc_done_q       <= 1'b0;
      cyc_count_q      <= '0;
    end else begin
      mmio_en_prev_q <= bus_io.mmio_wr_en;
      if (mmio_accept) begin
        mmio_addr_last_q <= bus_io.mmio_wr_addr;
        mmio_data_last_q <= bus_io.mmio_wr_data;
      end
      if (cyc_wr) begin
        cyc_count_q <= bus_io.mmio_wr_data;
        cyc_done_q  <= 1'b1;
      end
    end
  end

  assign bus_io.cyc_done  = cyc_done_q;
  assign bus_io.cyc_count = cyc_count_q;

  logic [7:0]     uart_mem [0:UART_DEPTH-1];
  logic [UAW-1:0] uart_wr_ptr_q, uart_rd_ptr_q;
  logic [UAW:0]   uart_cnt_q;
  logic           uart_pop_ok, uart_push_ok;

  // A full FIFO still accepts a push when a pop frees the head in the same cycle.
  assign uart_pop_ok  = bus_io.uart_pop && (uart_cnt_q != '0);
  assign uart_push_ok = uart_push && ((uart_cnt_q != UART_FULL) || uart_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_wr_ptr_q <= '0;
      uart_rd_ptr_q <= '0;
      uart_cnt_q    <= '0;
    end else begin
      if (uart_push_ok) uart_wr_ptr_q <= uart_wr_ptr_q + 1'b1;
      if (uart_pop_ok)  uart_rd_ptr_q <= uart_rd_ptr_q + 1'b1;
      case ({uart_push_ok, uart_pop_ok})
        2'b10:   uart_cnt_q <= uart_cnt_q + 1'b1;
        2'b01:   uart_cnt_q <= uart_cnt_q - 1'b1;
        default: uart_cnt_q <= uart_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (uart_push_ok) uart_mem[uart_wr_ptr_q] <= bus_io.mmio_wr_data[7:0];
  end

  assign bus_io.uart_valid = (uart_cnt_q != '0);
  assign bus_io.uart_byte  = (uart_cnt_q != '0) ? uart_mem[uart_rd_ptr_q] : 8'h00;
endmodule

// File: tb/tb_host_mem_responder.sv
// Directed bench for host_mem_responder: init pulse, line read/write timing, MMIO-to-UART
// deduplication, FIFO full/empty limits, read abort, cycle-count register and reset mid-read.
module tb_host_mem_responder;
  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  host_mem_responder_if bus_if();

  host_mem_responder #(
    .LINE_AW(8), .RD_LATENCY(4), .INIT_CYCLES(16), .UART_DEPTH(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if.slave)
  );

  localparam logic [511:0] LINE_A5 = {64{8'hA5}};
  localparam logic [511:0] LINE_D  = {16{32'hD00D_0003}};
  localparam logic [511:0] LINE_P  = {16{32'h1234_5677}};
  localparam logic [511:0] LINE_E  = {16{32'hEEEE_0007}};

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // host_init must pulse on exactly the INIT_CYCLES-th edge after reset release.
  task automatic wait_init();
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_eq((i == 16) ? "init_pulse" : "init_quiet", 512'(bus_if.host_init), 512'(i == 16));
      check_eq("no_ready_in_init", 512'(bus_if.host_rd_ready), 512'd0);
    end
    $display("init: pulse window checked");
  endtask

  task automatic host_write(input logic [63:0] addr, input logic [511:0] data);
    bit got = 1'b0;
    bus_if.cpu_addr                = addr;
    bus_if.host_data_bus_write_out = data;
    bus_if.host_wgo                = 1'b1;
    bus_if.host_we                 = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (bus_if.host_wr_ready) got = 1'b1;
    end
    check_eq("wr_ready_seen", 512'(got), 512'd1);
    bus_if.host_wgo = 1'b0;
    bus_if.host_we  = 1'b0;
    tick();
    check_eq("wr_ready_one_cycle", 512'(bus_if.host_wr_ready), 512'd0);
    $display("write addr=%0h", addr);
  endtask

  // One edge captures the request, then RD_LATENCY edges until ready.
  task automatic host_read(input logic [63:0] addr, input logic [511:0] exp);
    int lat = 0;
    bus_if.cpu_addr = addr;
    bus_if.host_rgo = 1'b1;
    while (!bus_if.host_rd_ready && lat < 20) begin
      tick();
      lat++;
      bus_if.cpu_addr = 64'h3F0;
    end
    check_eq("rd_latency", 512'(lat), 512'd5);
    check_eq("rd_data", bus_if.host_data_bus_read_in, exp);
    tick();
    tick();
    check_eq("rd_hold_ready", 512'(bus_if.host_rd_ready), 512'd1);
    check_eq("rd_hold_data", bus_if.host_data_bus_read_in, exp);
    bus_if.host_re  = 1'b1;
    bus_if.host_rgo = 1'b0;
    tick();
    bus_if.host_re = 1'b0;
    check_eq("rd_ready_drop", 512'(bus_if.host_rd_ready), 512'd0);
    check_eq("rd_data_zero", bus_if.host_data_bus_read_in, 512'd0);
    $display("read addr=%0h latency=%0d", addr, lat);
  endtask

  task automatic uart_pop_one();
    bus_if.uart_pop = 1'b1;
    tick();
    bus_if.uart_pop = 1'b0;
  endtask

  initial begin
    bit wr_seen;
    bit rd_seen;
    int n;
    rst                            = 1'b1;
    bus_if.cpu_addr                = '0;
    bus_if.host_rgo                = 1'b0;
    bus_if.host_re                 = 1'b0;
    bus_if.host_wgo                = 1'b0;
    bus_if.host_we                 = 1'b0;
    bus_if.host_data_bus_write_out = '0;
    bus_if.mmio_wr_en              = 1'b0;
    bus_if.mmio_wr_addr            = '0;
    bus_if.mmio_wr_data            = '0;
    bus_if.uart_pop                = 1'b0;
    repeat (3) tick();
    check_eq("rst_init", 512'(bus_if.host_init), 512'd0);
    check_eq("rst_rd_ready", 512'(bus_if.host_rd_ready), 512'd0);
    check_eq("rst_wr_ready", 512'(bus_if.host_wr_ready), 512'd0);
    check_eq("rst_rd_data", bus_if.host_data_bus_read_in, 512'd0);
    check_eq("rst_uart_valid", 512'(bus_if.uart_valid), 512'd0);
    check_eq("rst_cyc_done", 512'(bus_if.cyc_done), 512'd0);
    check_eq("rst_cyc_count", 512'(bus_if.cyc_count), 512'd0);
    rst = 1'b0;
    wait_init();

    host_write(64'h14, LINE_A5);
    host_read(64'h14, LINE_A5);
    host_write(64'hC, LINE_D);
    host_read(64'hC, LINE_D);

    // Read and write requested together: read is served from the old line first.
    host_write(64'h1C, LINE_P);
    bus_if.cpu_addr                = 64'h1C;
    bus_if.host_data_bus_write_out = LINE_E;
    bus_if.host_rgo                = 1'b1;
    bus_if.host_wgo                = 1'b1;
    bus_if.host_we                 = 1'b1;
    wr_seen = 1'b0;
    n = 0;
    while (!bus_if.host_rd_ready && n < 20) begin
      tick();
      n++;
      if (bus_if.host_wr_ready) wr_seen = 1'b1;
    end
    check_eq("prio_no_write_first", 512'(wr_seen), 512'd0);
    check_eq("prio_read_old_data", bus_if.host_data_bus_read_in, LINE_P);
    bus_if.host_re  = 1'b1;
    bus_if.host_rgo = 1'b0;
    tick();
    bus_if.host_re = 1'b0;
    n = 0;
    while (!bus_if.host_wr_ready && n < 10) begin
      tick();
      n++;
    end
    check_eq("prio_write_after", 512'(bus_if.host_wr_ready), 512'd1);
    bus_if.host_wgo = 1'b0;
    bus_if.host_we  = 1'b0;
    tick();
    host_read(64'h1C, LINE_E);

    // Held MMIO pair pushes once; a data change pushes again.
    bus_if.mmio_wr_en   = 1'b1;
    bus_if.mmio_wr_addr = 64'h40000;
    bus_if.mmio_wr_data = 32'h41;
    repeat (5) tick();
    bus_if.mmio_wr_data = 32'h42;
    repeat (3) tick();
    bus_if.mmio_wr_en = 1'b0;
    tick();
    check_eq("uart_first_valid", 512'(bus_if.uart_valid), 512'd1);
    check_eq("uart_first_byte", 512'(bus_if.uart_byte), 512'h41);
    uart_pop_one();
    check_eq("uart_second_byte", 512'(bus_if.uart_byte), 512'h42);
    uart_pop_one();
    check_eq("uart_dedup_empty", 512'(bus_if.uart_valid), 512'd0);
    $display("mmio: held pair deduplicated");

    // Nine pushes into eight entries: the ninth is dropped.
    bus_if.mmio_wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus_if.mmio_wr_data = 32'h50 + 32'(i);
      tick();
    end
    bus_if.mmio_wr_en = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      check_eq("uart_full_valid", 512'(bus_if.uart_valid), 512'd1);
      check_eq("uart_full_order", 512'(bus_if.uart_byte), 512'(8'h50 + 8'(i)));
      uart_pop_one();
      $display("uart pop byte %0d", i);
    end
    check_eq("uart_ninth_dropped", 512'(bus_if.uart_valid), 512'd0);
    uart_pop_one();
    check_eq("uart_pop_empty_valid", 512'(bus_if.uart_valid), 512'd0);
    check_eq("uart_pop_empty_byte", 512'(bus_if.uart_byte), 512'd0);

    // Read abort: rgo drops two cycles into the wait.
    bus_if.cpu_addr = 64'h14;
    bus_if.host_rgo = 1'b1;
    tick();
    tick();
    bus_if.host_rgo = 1'b0;
    rd_seen = 1'b0;
    repeat (8) begin
      tick();
      if (bus_if.host_rd_ready) rd_seen = 1'b1;
    end
    check_eq("abort_no_ready", 512'(rd_seen), 512'd0);
    host_read(64'h14, LINE_A5);

    check_eq("cyc_done_before", 512'(bus_if.cyc_done), 512'd0);
    bus_if.mmio_wr_en   = 1'b1;
    bus_if.mmio_wr_addr = 64'h10;
    bus_if.mmio_wr_data = 32'd1234;
    tick();
    tick();
    bus_if.mmio_wr_en = 1'b0;
    tick();
    check_eq("cyc_done", 512'(bus_if.cyc_done), 512'd1);
    check_eq("cyc_count", 512'(bus_if.cyc_count), 512'd1234);
    check_eq("cyc_no_uart", 512'(bus_if.uart_valid), 512'd0);
    $display("mmio: cycle count written");

    // Reset while read data is presented: ready drops without a clock edge.
    bus_if.cpu_addr = 64'h14;
    bus_if.host_rgo = 1'b1;
    n = 0;
    while (!bus_if.host_rd_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq("pre_rst_ready", 512'(bus_if.host_rd_ready), 512'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_ready", 512'(bus_if.host_rd_ready), 512'd0);
    check_eq("rst_async_data", bus_if.host_data_bus_read_in, 512'd0);
    check_eq("rst_async_cyc_done", 512'(bus_if.cyc_done), 512'd0);
    bus_if.host_rgo = 1'b0;
    tick();
    rst = 1'b0;
    wait_init();
    host_read(64'h14, LINE_A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
